// File: rtl/pending_encoder8_3_if.sv
// Request/offer bundle between the producer side and the encoder.
// The producer owns req/ready; the encoder owns valid/y/pend/ovf.
interface pending_encoder8_3_if;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] y;
  logic [7:0] pend;
  logic       ovf;

  modport master (
    output req,
    output ready,
    input  valid,
    input  y,
    input  pend,
    input  ovf
  );

  modport slave (
    input  req,
    input  ready,
    output valid,
    output y,
    output pend,
    output ovf
  );
endinterface

// File: rtl/pending_encoder8_3.sv
// Pending-request latch with 8:3 priority encoder and valid/ready offer.
// ROTATE=0 gives fixed priority (bit 0 first), ROTATE=1 round-robin.
module pending_encoder8_3 #(
  parameter int unsigned ROTATE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  pending_encoder8_3_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] y_q, y_d;
  logic [2:0] last_q, last_d;
  logic       ovf_q, ovf_d;

  logic       xfer;
  logic [7:0] clr;
  logic [2:0] start;
  logic       found;
  logic [2:0] pick;

  // Upward wrap-around search; iterating from the far end lets the
  // nearest set bit to s win the last assignment.
  function automatic logic [3:0] pri(
    input logic [7:0] v,
    input logic [2:0] s
  );
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = s + 3'(k);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    xfer   = (state_q == OFFER) && bus.ready;
    clr    = xfer ? (8'b1 << y_q) : 8'b0;
    pend_d = (pend_q & ~clr) | bus.req;
    ovf_d  = ovf_q | (|(bus.req & pend_q & ~clr));
    last_d = xfer ? y_q : last_q;
    // The search must start after the index being retired this edge.
    start  = (ROTATE != 0) ? last_d + 3'd1 : 3'd0;
    {found, pick} = pri(pend_d, start);

    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          y_d     = pick;
        end
      end
      OFFER: begin
        if (xfer) begin
          if (found) begin
            y_d = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 8'b0;
      y_q     <= 3'd0;
      last_q  <= 3'd7;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.valid = (state_q == OFFER);
  assign bus.y     = y_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Scoreboard bench: directed req/ready vectors push expected indices,
// per-DUT monitors pop and compare on every offered transfer.
module tb_pending_encoder8_3;

  logic clk;
  logic reset;

  pending_encoder8_3_if i0 ();
  pending_encoder8_3_if i1 ();

  pending_encoder8_3 #(.ROTATE(0)) d0 (
    .clk   (clk),
    .reset (reset),
    .bus   (i0)
  );

  pending_encoder8_3 #(.ROTATE(1)) d1 (
    .clk   (clk),
    .reset (reset),
    .bus   (i1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int q0[$];
  int q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && i0.valid && i0.ready) begin
      if (q0.size() == 0) begin
        check("y0_unexpected", {29'b0, i0.y}, 32'hFFFF_FFFF);
      end else begin
        check("y0", {29'b0, i0.y}, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && i1.valid && i1.ready) begin
      if (q1.size() == 0) begin
        check("y1_unexpected", {29'b0, i1.y}, 32'hFFFF_FFFF);
      end else begin
        check("y1", {29'b0, i1.y}, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    i0.req   = 8'h00;
    i0.ready = 1'b0;
    i1.req   = 8'h00;
    i1.ready = 1'b0;
    step();
    step();
    check("rst_valid0", {31'b0, i0.valid}, 0);
    check("rst_y0",     {29'b0, i0.y},     0);
    check("rst_pend0",  {24'b0, i0.pend},  0);
    check("rst_ovf0",   {31'b0, i0.ovf},   0);
    check("rst_valid1", {31'b0, i1.valid}, 0);
    #2 reset = 1'b0;
    step();

    // two requests drained in priority order
    i0.ready = 1'b1;
    i0.req   = 8'h24;
    q0.push_back(2);
    q0.push_back(5);
    step();
    i0.req = 8'h00;
    step();
    step();
    check("t1_valid", {31'b0, i0.valid}, 0);
    check("t1_pend",  {24'b0, i0.pend},  0);

    // offer held under backpressure despite higher-priority arrival
    i0.ready = 1'b0;
    i0.req   = 8'h20;
    step();
    i0.req = 8'h01;
    step();
    i0.req = 8'h00;
    check("t2_y",     {29'b0, i0.y},     5);
    check("t2_pend",  {24'b0, i0.pend},  32'h21);
    check("t2_valid", {31'b0, i0.valid}, 1);
    q0.push_back(5);
    q0.push_back(0);
    i0.ready = 1'b1;
    step();
    step();
    check("t2_idle", {31'b0, i0.valid}, 0);

    // overflow on a repeated pending bit, sticky afterwards
    i0.ready = 1'b0;
    i0.req   = 8'h08;
    step();
    i0.req = 8'h00;
    step();
    check("t3_ovf_pre", {31'b0, i0.ovf}, 0);
    i0.req = 8'h08;
    step();
    i0.req = 8'h00;
    check("t3_ovf_set", {31'b0, i0.ovf}, 1);
    q0.push_back(3);
    i0.ready = 1'b1;
    step();
    check("t3_idle",     {31'b0, i0.valid}, 0);
    check("t3_ovf_held", {31'b0, i0.ovf},   1);

    // set and clear on the same bit: re-offer, no overflow
    pulse_reset();
    i0.ready = 1'b0;
    i0.req   = 8'h10;
    step();
    i0.req = 8'h00;
    check("t4_y",     {29'b0, i0.y},     4);
    check("t4_valid", {31'b0, i0.valid}, 1);
    q0.push_back(4);
    q0.push_back(4);
    i0.ready = 1'b1;
    i0.req   = 8'h10;
    step();
    i0.req = 8'h00;
    check("t4_pend",   {24'b0, i0.pend},  32'h10);
    check("t4_ovf",    {31'b0, i0.ovf},   0);
    check("t4_y2",     {29'b0, i0.y},     4);
    check("t4_valid2", {31'b0, i0.valid}, 1);
    step();
    check("t4_idle",  {31'b0, i0.valid}, 0);
    check("t4_ovf2",  {31'b0, i0.ovf},   0);
    check("t4_pend2", {24'b0, i0.pend},  0);

    // fixed vs round-robin with two requests held
    pulse_reset();
    i0.ready = 1'b1;
    i1.ready = 1'b1;
    i0.req   = 8'h03;
    i1.req   = 8'h03;
    foreach (q0[i]) q0.delete(i);
    q0.push_back(0); q0.push_back(0); q0.push_back(0);
    q0.push_back(0); q0.push_back(1);
    q1.push_back(0); q1.push_back(1); q1.push_back(0);
    q1.push_back(1); q1.push_back(0);
    repeat (4) step();
    i0.req = 8'h00;
    i1.req = 8'h00;
    step();
    step();
    check("t5_idle0", {31'b0, i0.valid}, 0);
    check("t5_idle1", {31'b0, i1.valid}, 0);

    // round-robin sweep of all eight bits back-to-back
    pulse_reset();
    i1.req = 8'hFF;
    for (int k = 0; k < 8; k++) q1.push_back(k);
    step();
    i1.req = 8'h00;
    repeat (8) step();
    check("t5_sweep_idle", {31'b0, i1.valid}, 0);
    check("t5_sweep_pend", {24'b0, i1.pend},  0);
    check("t5_sweep_ovf",  {31'b0, i1.ovf},   0);

    // asynchronous reset mid-offer
    pulse_reset();
    i0.ready = 1'b0;
    i0.req   = 8'h90;
    step();
    step();
    i0.req = 8'h00;
    check("t6_pre_valid", {31'b0, i0.valid}, 1);
    check("t6_pre_pend",  {24'b0, i0.pend},  32'h90);
    check("t6_pre_y",     {29'b0, i0.y},     4);
    check("t6_pre_ovf",   {31'b0, i0.ovf},   1);
    #2 reset = 1'b1;
    #1;
    check("t6_valid", {31'b0, i0.valid}, 0);
    check("t6_y",     {29'b0, i0.y},     0);
    check("t6_pend",  {24'b0, i0.pend},  0);
    check("t6_ovf",   {31'b0, i0.ovf},   0);
    i0.req = 8'hFF;
    step();
    check("t6_req_ignored", {24'b0, i0.pend}, 0);
    i0.req = 8'h00;
    #1 reset = 1'b0;
    step();
    check("t6_after_valid", {31'b0, i0.valid}, 0);
    check("t6_after_pend",  {24'b0, i0.pend},  0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pending_encoder8_3.md
PENDING_ENCODER8_3 -- requirements
Module: pending_encoder8_3

Interface
REQ-001 SHALL have parameter: ROTATE, 0, priority mode (0 = fixed priority with bit 0 highest; 1 = round-robin).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  8  per-bit request pulses, sampled every rising edge of clk.
REQ-005 SHALL have port: ready  input  1  consumer accepts the offered index.
REQ-006 SHALL have port: valid  output  1  an encoded index is offered on y.
REQ-007 SHALL have port: y  output  3  binary index of the offered request.
REQ-008 SHALL have port: pend  output  8  registered pending-request vector.
REQ-009 SHALL have port: ovf  output  1  sticky overflow flag.

Function
REQ-010 SHALL define a transfer as valid=1 and ready=1 at a rising edge of clk.
REQ-011 SHALL compute clr as the one-hot of y on a transfer edge and as 0 otherwise.
REQ-012 SHALL update at each edge: pend <= (pend & ~clr) | req; set wins over clear on the same bit.
REQ-013 SHALL implement two states, IDLE (valid=0) and OFFER (valid=1); valid SHALL be decoded from the state register only.
REQ-014 SHALL, in IDLE, go to OFFER with y <= pri(pend_next) when pend_next != 0, and otherwise stay in IDLE with y unchanged.
REQ-015 SHALL, in OFFER without a transfer, hold y and state unchanged, even if a higher-priority request arrives.
REQ-016 SHALL, in OFFER with a transfer, load y <= pri(pend_next) and stay in OFFER when pend_next != 0, and otherwise go to IDLE.
REQ-017 SHALL define pri() as the first set bit found by searching upward with wrap-around from a start index.
REQ-018 SHALL use start index 0 when ROTATE=0.
REQ-019 SHALL, when ROTATE=1, use start index (last+1) mod 8, where last is a 3-bit register loaded with y on every transfer.
REQ-020 SHALL give a latency of one edge: a req bit sampled at edge k with the block in IDLE shows valid=1 immediately after edge k.
REQ-021 SHALL sustain one transfer per cycle while requests remain pending.
REQ-022 SHALL set ovf at an edge where req[i]=1, pend[i]=1 and clr[i]=0 for any i.
REQ-023 SHALL hold ovf at 1 until reset.
REQ-024 SHALL NOT flag overflow when a set and a clear hit the same bit on the same edge.
REQ-025 SHALL keep pend[y]=1 throughout OFFER; the offered bit is only cleared by its transfer.
REQ-026 SHALL ignore ready while in IDLE, with no effect on pend, y or last.

Reset
REQ-027 SHALL, on reset assertion, immediately and without a clock edge force: pend=0, state=IDLE, valid=0, y=0, ovf=0, last=7 (so the round-robin search starts at 0).
REQ-028 SHALL discard any in-flight offer when reset is asserted mid-operation.
REQ-029 SHALL ignore req while reset is asserted.
REQ-030 SHALL take its first update at the first clk edge after reset deasserts.

Verification
REQ-031 SHALL be verified by the bench with: ROTATE=0, ready=1, req=8'b0010_0100 for one cycle -> y=2 with valid for one cycle, then y=5 with valid for one cycle, then valid=0 and pend=0.
REQ-032 SHALL be verified by the bench with: ready=0 while y=5 is offered, then req[0] pulsed -> y stays 5 with pend=8'h21; when ready=1, one transfer of 5 and then y=0.
REQ-033 SHALL be verified by the bench with: ready=0, req[3] pulsed twice on different cycles -> ovf=1 after the second pulse, and ovf remains 1 after the later transfers.
REQ-034 SHALL be verified by the bench with: offer y=4, ready=1 and req[4]=1 on the same edge -> pend[4] stays 1, y=4 is offered again, and ovf=0.
REQ-035 SHALL be verified by the bench with: ready=1 and req=8'h03 held -> with ROTATE=0, y=0,0,0...; with ROTATE=1, y=0,1,0,1...; and with ROTATE=1 and one pulse of req=8'hFF, y=0..7 back-to-back, then valid=0.
REQ-036 SHALL be verified by the bench with: reset pulsed between clock edges while valid=1 and pend=8'h90 -> valid, y, pend and ovf go to 0 before the next edge.
